// File: rtl/insn_fetch_pkg.sv
// Shared types for the instruction fetch unit: opcode and addressing enums,
// the memory data byte type and the operand-length helper.
// Build option: ILLEGAL_OPCODE_EN enables decoding of undocumented opcodes.
package insn_fetch_pkg;

    typedef logic [7:0] dataLogic;

    // Documented mnemonics first, undocumented ones (SLO..KIL) after them
    typedef enum logic [6:0] {
        ADC, AND, ASL, BCC, BCS, BEQ, BIT, BMI, BNE, BPL, BRK, BVC, BVS, CLC,
        CLD, CLI, CLV, CMP, CPX, CPY, DEC, DEX, DEY, EOR, INC, INX, INY, JMP,
        JSR, LDA, LDX, LDY, LSR, NOP, ORA, PHA, PHP, PLA, PLP, ROL, ROR, RTI,
        RTS, SBC, SEC, SED, SEI, STA, STX, STY, TAX, TAY, TSX, TXA, TXS, TYA,
        SLO, RLA, SRE, RRA, SAX, LAX, DCP, ISC, ANC, ALR, ARR, XAA, AXS, AHX,
        SHY, SHX, TAS, LAS, KIL
    } Opcode;

    typedef enum logic [3:0] {
        Imp, Imm, Zpg, ZpgX, ZpgY, Abs, AbsX, AbsY, Ind, IndX, IndY, Rlt
    } Addressing;

    typedef enum logic [2:0] {
        IDLE, OPC, OP1, OP2, HOLD
    } FetchState;

    // Number of operand bytes following the opcode byte
    function automatic logic [1:0] operandLength(input Addressing m);
        case (m)
            Imp:                                  return 2'd0;
            Imm, Zpg, ZpgX, ZpgY, IndX, IndY, Rlt: return 2'd1;
            default:                              return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/insn_fetch_opcode_decode.sv
// Combinational opcode decoder: opcode byte -> mnemonic and addressing mode.
// Documented opcodes are decoded from the aaabbbcc bit layout; everything else
// becomes NOP/Imp unless ILLEGAL_OPCODE_EN is defined, in which case the
// undocumented opcodes decode to SLO..KIL with their real addressing modes.
module opcode_decode
    import insn_fetch_pkg::*;
(
    input  dataLogic  opByte,
    output Opcode     op,
    output Addressing mode
);

    logic [2:0] aaa;
    logic [2:0] bbb;
    logic [1:0] cc;
    logic       legal;
    Opcode      legalOp;
    Addressing  legalMode;
    Opcode      illOp;
    Addressing  illMode;

    assign aaa = opByte[7:5];
    assign bbb = opByte[4:2];
    assign cc  = opByte[1:0];

    // Addressing used by the cc=01 / cc=11 column layout
    function automatic Addressing columnMode(input logic [2:0] b);
        case (b)
            3'd0:    return IndX;
            3'd1:    return Zpg;
            3'd2:    return Imm;
            3'd3:    return Abs;
            3'd4:    return IndY;
            3'd5:    return ZpgX;
            3'd6:    return AbsY;
            default: return AbsX;
        endcase
    endfunction

    function automatic Opcode groupOneOp(input logic [2:0] a);
        case (a)
            3'd0:    return ORA;
            3'd1:    return AND;
            3'd2:    return EOR;
            3'd3:    return ADC;
            3'd4:    return STA;
            3'd5:    return LDA;
            3'd6:    return CMP;
            default: return SBC;
        endcase
    endfunction

    function automatic Opcode shiftOp(input logic [2:0] a);
        case (a)
            3'd0:    return ASL;
            3'd1:    return ROL;
            3'd2:    return LSR;
            3'd3:    return ROR;
            3'd4:    return STX;
            3'd5:    return LDX;
            3'd6:    return DEC;
            default: return INC;
        endcase
    endfunction

    function automatic Opcode indexOp(input logic [2:0] a);
        case (a)
            3'd1:    return BIT;
            3'd2:    return JMP;
            3'd3:    return JMP;
            3'd4:    return STY;
            3'd5:    return LDY;
            3'd6:    return CPY;
            3'd7:    return CPX;
            default: return NOP;
        endcase
    endfunction

    // Column bbb=0 of cc=00 for aaa<4: interrupt and subroutine control
    function automatic Opcode controlOp(input logic [2:0] a);
        case (a)
            3'd0:    return BRK;
            3'd1:    return JSR;
            3'd2:    return RTI;
            default: return RTS;
        endcase
    endfunction

    function automatic Opcode stackOp(input logic [2:0] a);
        case (a)
            3'd0:    return PHP;
            3'd1:    return PLP;
            3'd2:    return PHA;
            3'd3:    return PLA;
            3'd4:    return DEY;
            3'd5:    return TAY;
            3'd6:    return INY;
            default: return INX;
        endcase
    endfunction

    function automatic Opcode branchOp(input logic [2:0] a);
        case (a)
            3'd0:    return BPL;
            3'd1:    return BMI;
            3'd2:    return BVC;
            3'd3:    return BVS;
            3'd4:    return BCC;
            3'd5:    return BCS;
            3'd6:    return BNE;
            default: return BEQ;
        endcase
    endfunction

    function automatic Opcode flagOp(input logic [2:0] a);
        case (a)
            3'd0:    return CLC;
            3'd1:    return SEC;
            3'd2:    return CLI;
            3'd3:    return SEI;
            3'd4:    return TYA;
            3'd5:    return CLV;
            3'd6:    return CLD;
            default: return SED;
        endcase
    endfunction

    // Documented opcode decode; legal flags which bytes are real instructions
    always_comb begin
        legalOp   = NOP;
        legalMode = Imp;
        legal     = 1'b0;
        case (cc)
            2'b01: begin
                legalOp   = groupOneOp(aaa);
                legalMode = columnMode(bbb);
                legal     = (opByte != 8'h89);
            end
            2'b10: begin
                case (bbb)
                    3'd0: begin
                        if (aaa == 3'd5) begin
                            legalOp   = LDX;
                            legalMode = Imm;
                            legal     = 1'b1;
                        end
                    end
                    3'd1, 3'd3: begin
                        legalOp   = shiftOp(aaa);
                        legalMode = (bbb == 3'd1) ? Zpg : Abs;
                        legal     = 1'b1;
                    end
                    3'd2: begin
                        // Accumulator shifts carry no operand, so they are Imp
                        case (aaa)
                            3'd4:    legalOp = TXA;
                            3'd5:    legalOp = TAX;
                            3'd6:    legalOp = DEX;
                            3'd7:    legalOp = NOP;
                            default: legalOp = shiftOp(aaa);
                        endcase
                        legal = 1'b1;
                    end
                    3'd5: begin
                        legalOp   = shiftOp(aaa);
                        legalMode = (aaa == 3'd4 || aaa == 3'd5) ? ZpgY : ZpgX;
                        legal     = 1'b1;
                    end
                    3'd6: begin
                        if (aaa == 3'd4 || aaa == 3'd5) begin
                            legalOp = (aaa == 3'd4) ? TXS : TSX;
                            legal   = 1'b1;
                        end
                    end
                    3'd7: begin
                        if (aaa != 3'd4) begin
                            legalOp   = shiftOp(aaa);
                            legalMode = (aaa == 3'd5) ? AbsY : AbsX;
                            legal     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            2'b00: begin
                case (bbb)
                    3'd0: begin
                        if (aaa <= 3'd3) begin
                            legalOp   = controlOp(aaa);
                            legalMode = (aaa == 3'd1) ? Abs : Imp;
                            legal     = 1'b1;
                        end else if (aaa >= 3'd5) begin
                            legalOp   = indexOp(aaa);
                            legalMode = Imm;
                            legal     = 1'b1;
                        end
                    end
                    3'd1: begin
                        if (aaa == 3'd1 || aaa >= 3'd4) begin
                            legalOp   = indexOp(aaa);
                            legalMode = Zpg;
                            legal     = 1'b1;
                        end
                    end
                    3'd2: begin
                        legalOp = stackOp(aaa);
                        legal   = 1'b1;
                    end
                    3'd3: begin
                        if (aaa != 3'd0) begin
                            legalOp   = indexOp(aaa);
                            legalMode = (aaa == 3'd3) ? Ind : Abs;
                            legal     = 1'b1;
                        end
                    end
                    3'd4: begin
                        legalOp   = branchOp(aaa);
                        legalMode = Rlt;
                        legal     = 1'b1;
                    end
                    3'd5: begin
                        if (aaa == 3'd4 || aaa == 3'd5) begin
                            legalOp   = indexOp(aaa);
                            legalMode = ZpgX;
                            legal     = 1'b1;
                        end
                    end
                    3'd6: begin
                        legalOp = flagOp(aaa);
                        legal   = 1'b1;
                    end
                    default: begin
                        if (aaa == 3'd5) begin
                            legalOp   = LDY;
                            legalMode = AbsX;
                            legal     = 1'b1;
                        end
                    end
                endcase
            end
            default: ;
        endcase
    end

`ifdef ILLEGAL_OPCODE_EN
    function automatic Opcode rmwOp(input logic [2:0] a);
        case (a)
            3'd0:    return SLO;
            3'd1:    return RLA;
            3'd2:    return SRE;
            3'd3:    return RRA;
            3'd4:    return SAX;
            3'd5:    return LAX;
            3'd6:    return DCP;
            default: return ISC;
        endcase
    endfunction

    function automatic Opcode immOp(input logic [2:0] a);
        case (a)
            3'd0, 3'd1: return ANC;
            3'd2:       return ALR;
            3'd3:       return ARR;
            3'd4:       return XAA;
            3'd5:       return LAX;
            3'd6:       return AXS;
            default:    return SBC;
        endcase
    endfunction

    // Undocumented opcode decode; only consulted when the byte is not legal
    always_comb begin
        illOp   = NOP;
        illMode = Imp;
        case (cc)
            2'b11: begin
                illOp   = rmwOp(aaa);
                illMode = columnMode(bbb);
                if (bbb == 3'd2) begin
                    illOp   = immOp(aaa);
                    illMode = Imm;
                end else if (aaa == 3'd4 || aaa == 3'd5) begin
                    // SAX/LAX index with Y where the column would use X
                    if (bbb == 3'd5) begin
                        illMode = ZpgY;
                    end else if (bbb == 3'd7) begin
                        illMode = AbsY;
                    end
                end
                case (opByte)
                    8'h93, 8'h9F: illOp = AHX;
                    8'h9B:        illOp = TAS;
                    8'hBB:        illOp = LAS;
                    default:      ;
                endcase
            end
            2'b10: begin
                case (bbb)
                    3'd0: begin
                        illOp   = (aaa < 3'd4) ? KIL : NOP;
                        illMode = (aaa < 3'd4) ? Imp : Imm;
                    end
                    3'd4:    illOp = KIL;
                    3'd7: begin
                        illOp   = SHX;
                        illMode = AbsY;
                    end
                    default: ;
                endcase
            end
            2'b01: begin
                illMode = Imm;
            end
            default: begin
                case (bbb)
                    3'd0:    illMode = Imm;
                    3'd1:    illMode = Zpg;
                    3'd3:    illMode = Abs;
                    3'd5:    illMode = ZpgX;
                    3'd7: begin
                        illOp   = (aaa == 3'd4) ? SHY : NOP;
                        illMode = AbsX;
                    end
                    default: ;
                endcase
            end
        endcase
    end
`else
    assign illOp   = NOP;
    assign illMode = Imp;
`endif

    assign op   = legal ? legalOp : illOp;
    assign mode = legal ? legalMode : illMode;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch unit: reads opcode and operand bytes over a simple
// req/ack byte port, decodes them and presents one instruction at a time on a
// valid/ready interface. pc_load redirects the stream; a request already in
// flight is allowed to complete and its data is dropped.
// Build option: ILLEGAL_OPCODE_EN decodes undocumented opcodes and makes KIL
// hold the output stage until redirect or reset.
module insn_fetch
    import insn_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'hFFFC
) (
    input  logic        clk,
    input  logic        n_reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  dataLogic    mem_rdata,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic        valid,
    input  logic        ready,
    output Opcode       op,
    output Addressing   mode,
    output logic [15:0] operand,
    output logic [15:0] insn_pc
);

    FetchState   state;
    logic [15:0] pc;
    logic [15:0] pcNext;
    logic        flushPending;
    logic        reqDone;
    logic        kilStuck;
    Opcode       decOp;
    Addressing   decMode;

    opcode_decode decoder (
        .opByte (mem_rdata),
        .op     (decOp),
        .mode   (decMode)
    );

    assign pcNext  = pc + 16'd1;
    assign reqDone = mem_req && mem_ack;

`ifdef ILLEGAL_OPCODE_EN
    assign kilStuck = (op == KIL);
`else
    assign kilStuck = 1'b0;
`endif

    // Fetch FSM, pc and handshake; every output is registered here
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            mem_req      <= 1'b0;
            mem_addr     <= RESET_PC;
            valid        <= 1'b0;
            op           <= NOP;
            mode         <= Imp;
            operand      <= 16'h0000;
            insn_pc      <= 16'h0000;
            flushPending <= 1'b0;
        end else if (pc_load) begin
            // Redirect wins over everything, including a consumed instruction
            pc    <= pc_in;
            valid <= 1'b0;
            state <= OPC;
            if (mem_req && !mem_ack) begin
                flushPending <= 1'b1;
            end else begin
                flushPending <= 1'b0;
                mem_req      <= 1'b1;
                mem_addr     <= pc_in;
            end
        end else if (flushPending) begin
            // Let the stale request finish, drop its byte, then ask for pc
            if (mem_ack) begin
                flushPending <= 1'b0;
                mem_addr     <= pc;
            end
        end else begin
            case (state)
                IDLE: begin
                    state    <= OPC;
                    mem_req  <= 1'b1;
                    mem_addr <= pc;
                end
                OPC: begin
                    if (reqDone) begin
                        op      <= decOp;
                        mode    <= decMode;
                        insn_pc <= pc;
                        operand <= 16'h0000;
                        pc      <= pcNext;
                        if (operandLength(decMode) != 2'd0) begin
                            state    <= OP1;
                            mem_addr <= pcNext;
                        end else begin
                            state   <= HOLD;
                            mem_req <= 1'b0;
                            valid   <= 1'b1;
                        end
                    end
                end
                OP1: begin
                    if (reqDone) begin
                        operand <= {8'h00, mem_rdata};
                        pc      <= pcNext;
                        if (operandLength(mode) == 2'd2) begin
                            state    <= OP2;
                            mem_addr <= pcNext;
                        end else begin
                            state   <= HOLD;
                            mem_req <= 1'b0;
                            valid   <= 1'b1;
                        end
                    end
                end
                OP2: begin
                    if (reqDone) begin
                        operand[15:8] <= mem_rdata;
                        pc            <= pcNext;
                        state         <= HOLD;
                        mem_req       <= 1'b0;
                        valid         <= 1'b1;
                    end
                end
                HOLD: begin
                    if (valid && ready && !kilStuck) begin
                        valid    <= 1'b0;
                        state    <= OPC;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_insn_fetch.sv
// Directed testbench for insn_fetch: a byte memory with programmable ack
// delay feeds the fetch unit, and hand-computed instruction fields are checked.
module tb_insn_fetch;
    import insn_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    dataLogic    mem_rdata = 8'h00;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic        valid;
    logic        ready = 1'b0;
    Opcode       op;
    Addressing   mode;
    logic [15:0] operand;
    logic [15:0] insn_pc;

    logic [7:0]  memory [0:65535];
    int          ackDelay = 0;
    int          waitCnt = 0;
    int          total = 0;
    int          bad = 0;

    insn_fetch dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .pc_load   (pc_load),
        .pc_in     (pc_in),
        .valid     (valid),
        .ready     (ready),
        .op        (op),
        .mode      (mode),
        .operand   (operand),
        .insn_pc   (insn_pc)
    );

    always #5 clk = ~clk;

    // Memory model: acks a request after ackDelay idle cycles
    always @(negedge clk) begin
        if (mem_req && n_reset) begin
            if (waitCnt >= ackDelay) begin
                mem_ack   = 1'b1;
                mem_rdata = memory[mem_addr];
                waitCnt   = 0;
            end else begin
                mem_ack = 1'b0;
                waitCnt = waitCnt + 1;
            end
        end else begin
            mem_ack = 1'b0;
            waitCnt = 0;
        end
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic checkInsn(input string tag, input Opcode eOp, input Addressing eMode,
                             input logic [15:0] eOperand, input logic [15:0] ePc);
        checkVal({tag, "_op"}, 32'(op), 32'(eOp));
        checkVal({tag, "_mode"}, 32'(mode), 32'(eMode));
        checkVal({tag, "_operand"}, 32'(operand), 32'(eOperand));
        checkVal({tag, "_pc"}, 32'(insn_pc), 32'(ePc));
    endtask

    task automatic waitValid(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!valid && cycles < 60);
        checkVal({tag, "_valid"}, 32'(valid), 32'd1);
    endtask

    task automatic waitReq(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!mem_req && cycles < 60);
        checkVal({tag, "_req"}, 32'(mem_req), 32'd1);
    endtask

    task automatic doLoad(input logic [15:0] target);
        pc_load = 1'b1;
        pc_in   = target;
        @(posedge clk);
        #1;
        pc_load = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "_req"}, 32'(mem_req), 32'd0);
        checkVal({tag, "_addr"}, 32'(mem_addr), 32'hFFFC);
        checkVal({tag, "_valid"}, 32'(valid), 32'd0);
        checkInsn(tag, NOP, Imp, 16'h0000, 16'h0000);
    endtask

    initial begin
        int          cyc;
        int          stable;
        logic [7:0]  prog [0:16];
        Opcode       tOp [0:8];
        Addressing   tMode [0:8];
        logic [15:0] tOperand [0:8];
        logic [15:0] tPc [0:8];

        foreach (memory[i]) memory[i] = 8'h00;
        memory[16'hFFFC] = 8'hEA;
        memory[16'h8000] = 8'hA9; memory[16'h8001] = 8'h42;
        memory[16'h8002] = 8'hAD; memory[16'h8003] = 8'h34; memory[16'h8004] = 8'h12;
        memory[16'h8005] = 8'h6C; memory[16'h8006] = 8'h00; memory[16'h8007] = 8'h02;
        memory[16'h8008] = 8'hEA;
        memory[16'hC000] = 8'h18;
        memory[16'hFFFF] = 8'h02;
        memory[16'h0000] = 8'hEA;
        memory[16'h0100] = 8'hAD;

        prog = '{8'h00, 8'h20, 8'h34, 8'h12, 8'h0A, 8'hB6, 8'h10, 8'h91, 8'h20,
                 8'hF0, 8'hFE, 8'hBD, 8'hFF, 8'h00, 8'h6A, 8'hA7, 8'h10};
        for (int i = 0; i < 17; i++) memory[16'(i + 1)] = prog[i];
        tOp      = '{BRK, JSR, ASL, LDX, STA, BEQ, LDA, ROR, NOP};
        tMode    = '{Imp, Abs, Imp, ZpgY, IndY, Rlt, AbsX, Imp, Imp};
        tOperand = '{16'h0000, 16'h1234, 16'h0000, 16'h0010, 16'h0020,
                     16'h00FE, 16'h00FF, 16'h0000, 16'h0000};
        tPc      = '{16'h0001, 16'h0002, 16'h0005, 16'h0006, 16'h0008,
                     16'h000A, 16'h000C, 16'h000F, 16'h0010};
`ifdef ILLEGAL_OPCODE_EN
        tOp[8]      = LAX;
        tMode[8]    = Zpg;
        tOperand[8] = 16'h0010;
`endif

        // Reset values, then first fetch at the reset vector
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("reset");
        n_reset = 1'b1;
        waitReq("boot", cyc);
        checkVal("boot_addr", 32'(mem_addr), 32'hFFFC);
        waitValid("boot", cyc);
        checkInsn("boot", NOP, Imp, 16'h0000, 16'hFFFC);

        // Redirect to 0x8000: LDA #$42
        doLoad(16'h8000);
        checkVal("load_valid_drop", 32'(valid), 32'd0);
        checkVal("load_addr", 32'(mem_addr), 32'h8000);
        ready = 1'b1;
        waitValid("lda_imm", cyc);
        checkVal("lda_imm_latency", 32'(cyc), 32'd2);
        checkInsn("lda_imm", LDA, Imm, 16'h0042, 16'h8000);
        @(posedge clk);
        #1;
        checkVal("lda_imm_consumed", 32'(valid), 32'd0);
        checkVal("next_addr", 32'(mem_addr), 32'h8002);
        ready = 1'b0;

        // LDA $1234 held for 10 cycles with ready low
        waitValid("lda_abs", cyc);
        checkVal("lda_abs_latency", 32'(cyc), 32'd3);
        checkInsn("lda_abs", LDA, Abs, 16'h1234, 16'h8002);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkVal("hold_req", 32'(mem_req), 32'd0);
            checkVal("hold_valid", 32'(valid), 32'd1);
            checkVal("hold_op", 32'(op), 32'(LDA));
            checkVal("hold_operand", 32'(operand), 32'h1234);
            checkVal("hold_pc", 32'(insn_pc), 32'h8002);
        end
        ready = 1'b1;
        @(posedge clk);
        #1;
        checkVal("resume_valid", 32'(valid), 32'd0);
        checkVal("resume_req", 32'(mem_req), 32'd1);
        checkVal("resume_addr", 32'(mem_addr), 32'h8005);
        ready = 1'b0;

        waitValid("jmp_ind", cyc);
        checkVal("jmp_ind_latency", 32'(cyc), 32'd3);
        checkInsn("jmp_ind", JMP, Ind, 16'h0200, 16'h8005);

        // Redirect to 0xC000 while a slow request is outstanding
        ready = 1'b1;
        ackDelay = 3;
        @(posedge clk);
        #1;
        checkVal("slow_addr", 32'(mem_addr), 32'h8008);
        ready = 1'b0;
        doLoad(16'hC000);
        stable = 0;
        while (mem_addr == 16'h8008 && stable < 20) begin
            checkVal("flush_req", 32'(mem_req), 32'd1);
            checkVal("flush_valid", 32'(valid), 32'd0);
            stable++;
            @(posedge clk);
            #1;
        end
        checkVal("flush_stable_cycles", 32'(stable), 32'd3);
        checkVal("flush_new_addr", 32'(mem_addr), 32'hC000);
        waitValid("clc", cyc);
        checkInsn("clc", CLC, Imp, 16'h0000, 16'hC000);
        ackDelay = 0;

        // pc_load coincident with consume, then opcode 0x02 at 0xFFFF
        ready = 1'b1;
        doLoad(16'hFFFF);
        checkVal("coincide_valid", 32'(valid), 32'd0);
        checkVal("coincide_addr", 32'(mem_addr), 32'hFFFF);
        waitValid("op02", cyc);
        checkVal("op02_latency", 32'(cyc), 32'd1);
`ifdef ILLEGAL_OPCODE_EN
        checkInsn("op02", KIL, Imp, 16'h0000, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checkVal("kil_valid", 32'(valid), 32'd1);
            checkVal("kil_req", 32'(mem_req), 32'd0);
        end
        doLoad(16'h0000);
`else
        checkInsn("op02", NOP, Imp, 16'h0000, 16'hFFFF);
        @(posedge clk);
        #1;
`endif
        checkVal("wrap_req", 32'(mem_req), 32'd1);
        checkVal("wrap_addr", 32'(mem_addr), 32'h0000);
        waitValid("wrap_nop", cyc);
        checkInsn("wrap_nop", NOP, Imp, 16'h0000, 16'h0000);

        // Decode table, streaming with ready held high
        for (int i = 0; i < 9; i++) begin
            waitValid($sformatf("tbl%0d", i), cyc);
            checkInsn($sformatf("tbl%0d", i), tOp[i], tMode[i], tOperand[i], tPc[i]);
        end

        // Reset pulse while waiting for the first operand byte
        ready = 1'b0;
        ackDelay = 2;
        doLoad(16'h0100);
        stable = 0;
        while (mem_addr != 16'h0101 && stable < 20) begin
            @(posedge clk);
            #1;
            stable++;
        end
        checkVal("op1_addr", 32'(mem_addr), 32'h0101);
        checkVal("op1_opcode", 32'(op), 32'(LDA));
        #2;
        n_reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        @(posedge clk);
        #1;
        n_reset = 1'b1;
        waitReq("reboot", cyc);
        checkVal("reboot_addr", 32'(mem_addr), 32'hFFFC);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/insn_fetch.md
INSN_FETCH -- requirements
Module: insn_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'hFFFC, giving the first fetch address after reset.
REQ-002 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have ports: n_reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: mem_req  out  1  read request; mem_addr  out  16  read address; mem_ack  in  1  request accepted, data valid this cycle; mem_rdata  in  8  (dataLogic) read byte.
REQ-005 SHALL have ports: pc_load  in  1  redirect; pc_in  in  16  redirect target.
REQ-006 SHALL have ports: valid  out  1  instruction available; ready  in  1  consumer accepts; op  out  Opcode; mode  out  Addressing; operand  out  16  {hi,lo}, zero-extended; insn_pc  out  16  opcode byte address.

Function
REQ-007 SHALL implement states IDLE, OPC, OP1, OP2, HOLD, with IDLE only following reset and entering OPC on the next cycle.
REQ-008 SHALL keep mem_req, mem_addr and the state unchanged until mem_ack, with one request outstanding at most.
REQ-009 OPC SHALL request pc, and on ack latch op/mode/insn_pc, increment pc, and enter OP1 if operand length > 0, else HOLD.
REQ-010 SHALL assign operand length 0 for Imp, 1 for Imm/Zpg/ZpgX/ZpgY/IndX/IndY/Rlt, and 2 for Abs/AbsX/AbsY/Ind.
REQ-011 OP1 SHALL latch operand[7:0], clear operand[15:8], increment pc, and enter OP2 if length = 2, else HOLD.
REQ-012 OP2 SHALL latch operand[15:8], increment pc, and enter HOLD.
REQ-013 HOLD SHALL assert valid with all output fields stable, deassert mem_req, and, when valid && ready, enter OPC the next cycle.
REQ-014 SHALL have latency from the final byte's ack to valid of exactly 1 cycle, giving a minimum per-instruction throughput of (1 + length) acks + 1 cycle.
REQ-015 SHALL increment pc modulo 2^16, with 16'hFFFF wrapping to 16'h0000.
REQ-016 pc_load SHALL set pc = pc_in, drop valid the next cycle, discard any partially fetched instruction, and restart in OPC.
REQ-017 If a request is outstanding during pc_load, SHALL hold that request until ack, discard its data, then issue pc_in.
REQ-018 On pc_load coincident with valid && ready, pc_load SHALL win, and the held instruction counts as consumed.
REQ-019 Decoded BRK SHALL be Imp/length 0, and JSR SHALL be Abs/length 2.
REQ-020 SHALL decode accumulator shifts as Imp.

Reset
REQ-021 While n_reset is low, SHALL hold state IDLE, pc = RESET_PC, mem_req = 0, mem_addr = RESET_PC, valid = 0, op = NOP, mode = Imp, operand = 0, insn_pc = 0.
REQ-022 Reset asserted mid-fetch SHALL abandon the transaction immediately, with no wait for mem_ack.

Configuration
REQ-023 SHALL use macro ILLEGAL_OPCODE_EN.
REQ-024 With ILLEGAL_OPCODE_EN defined, SHALL decode undocumented opcodes to SLO..KIL with their true addressing modes.
REQ-025 With ILLEGAL_OPCODE_EN defined, after presenting KIL, SHALL stay in HOLD with valid held high regardless of ready, until pc_load or reset.
REQ-026 With ILLEGAL_OPCODE_EN undefined, SHALL decode every undocumented opcode as NOP/Imp/length 0.

Structure
REQ-027 Opcode, Addressing, dataLogic and a new operand-length helper function SHALL reside in the shared package.
REQ-028 SHALL contain one combinational sub-module opcode_decode (byte -> Opcode, Addressing), with ILLEGAL_OPCODE_EN applied inside it.
REQ-029 The FSM, pc and handshake SHALL live in insn_fetch.

Verification
REQ-030 Memory 0x8000: A9 42, pc_load to 0x8000, ready=1 -> one valid: LDA, Imm, operand 0x0042, insn_pc 0x8000; next request at 0x8002.
REQ-031 AD 34 12 then 6C 00 02 -> LDA Abs 0x1234, then JMP Ind 0x0200; each held valid exactly until ready.
REQ-032 ready=0 for 10 cycles after valid -> mem_req low, outputs unchanged for all 10 cycles; fetch resumes 1 cycle after ready.
REQ-033 mem_ack delayed 3 cycles while pc_load to 0xC000 -> mem_req/mem_addr stable until ack, data discarded, next request at 0xC000, no valid for the old instruction.
REQ-034 Byte 0x02 at 0xFFFF -> with ILLEGAL_OPCODE_EN: KIL, valid stuck high until pc_load; without: NOP/Imp, next fetch at 0x0000.
REQ-035 Pulse n_reset low during OP1 -> all outputs at reset values immediately; first request after release at RESET_PC.
